// File: rtl/sp_ram_pkg.sv
//------------------------------------------------------------------------------
// sp_ram_pkg : shared encodings for the single-port RAM controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sp_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

`default_nettype wire

// File: rtl/sp_ram_ctrl_if.sv
//------------------------------------------------------------------------------
// sp_ram_ctrl_if : access/clear bus between a requester and sp_ram_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sp_ram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic                  en;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  dout_valid;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output en, we, be, addr, din, clr_req,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  en, we, be, addr, din, clr_req,
        output dout, dout_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/sp_ram_clr_seq.sv
//------------------------------------------------------------------------------
// sp_ram_clr_seq : owns the array while sweeping zeros through every word
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sp_ram_clr_seq
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr_req,
    output logic                   busy,
    output logic [ADDR_W-1:0]      ptr
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Pointer wraps to zero after the last word, so READY always restarts at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_last_addr) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == ST_CLEAR);
    assign ptr  = r_ptr;

endmodule

`default_nettype wire

// File: rtl/sp_ram_ctrl.sv
//------------------------------------------------------------------------------
// sp_ram_ctrl : byte-enabled single-port RAM with clear sequencer and read pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int RDW_MODE = RDW_READ_FIRST,
    parameter int OUT_REG  = 0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    sp_ram_ctrl_if.slave  bus
);

    localparam int c_nbytes = DATA_W / 8;
    localparam int c_depth  = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_access;
    logic              w_write;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;

    sp_ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (bus.clr_req),
        .busy    (w_busy),
        .ptr     (w_clr_ptr)
    );

    assign w_access = bus.en & ~w_busy;
    assign w_write  = w_access & bus.we;
    assign w_old    = r_mem[bus.addr];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < c_nbytes; i++) begin
            if (bus.be[i]) begin
                w_merged[8*i +: 8] = bus.din[8*i +: 8];
            end
        end
    end

    assign w_rd_data = ((RDW_MODE == RDW_WRITE_FIRST) && bus.we) ? w_merged : w_old;

    // Array has no reset: contents are only zeroed by the clear sweep.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_ptr] <= '0;
        end else if (w_write) begin
            r_mem[bus.addr] <= w_merged;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_p1_valid;
            logic [DATA_W-1:0] r_p1_data;

            // Stage two drains regardless of busy so in-flight reads finish.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p1_valid   <= 1'b0;
                    r_p1_data    <= '0;
                    r_dout_valid <= 1'b0;
                    r_dout       <= '0;
                end else begin
                    r_p1_valid   <= w_access;
                    if (w_access) begin
                        r_p1_data <= w_rd_data;
                    end
                    r_dout_valid <= r_p1_valid;
                    if (r_p1_valid) begin
                        r_dout <= r_p1_data;
                    end
                end
            end
        end else begin : g_out_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout_valid <= 1'b0;
                    r_dout       <= '0;
                end else begin
                    r_dout_valid <= w_access;
                    if (w_access) begin
                        r_dout <= w_rd_data;
                    end
                end
            end
        end
    endgenerate

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_sp_ram_ctrl.sv
//------------------------------------------------------------------------------
// tb_sp_ram_ctrl : three configurations driven in lockstep against one model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sp_ram_ctrl;
    import sp_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(2)) if0 ();
    sp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(2)) if1 ();
    sp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(2)) if2 ();

    sp_ram_ctrl #(.DATA_W(16), .ADDR_W(2), .RDW_MODE(RDW_READ_FIRST), .OUT_REG(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sp_ram_ctrl #(.DATA_W(16), .ADDR_W(2), .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(0))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sp_ram_ctrl #(.DATA_W(16), .ADDR_W(2), .RDW_MODE(RDW_READ_FIRST), .OUT_REG(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: memory contents, clear progress, expected outputs.
    logic [15:0] m_mem [4];
    bit          m_busy;
    logic [1:0]  m_ptr;
    logic [15:0] e_dout [3];
    bit          e_valid [3];
    bit          p_valid;
    logic [15:0] p_data;

    bit          s_en, s_we, s_clr;
    logic [1:0]  s_be, s_addr;
    logic [15:0] s_din;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit en, input bit we, input logic [1:0] be,
                         input logic [1:0] addr, input logic [15:0] din, input bit clr);
        s_en = en; s_we = we; s_be = be; s_addr = addr; s_din = din; s_clr = clr;
        if0.en = en; if0.we = we; if0.be = be; if0.addr = addr; if0.din = din; if0.clr_req = clr;
        if1.en = en; if1.we = we; if1.be = be; if1.addr = addr; if1.din = din; if1.clr_req = clr;
        if2.en = en; if2.we = we; if2.be = be; if2.addr = addr; if2.din = din; if2.clr_req = clr;
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_ptr  = 2'd0;
        p_valid = 1'b0;
        p_data  = 16'h0;
        for (int k = 0; k < 3; k++) begin
            e_dout[k]  = 16'h0;
            e_valid[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] old_w, new_w;
        bit acc;
        old_w = m_mem[s_addr];
        new_w = old_w;
        for (int b = 0; b < 2; b++)
            if (s_be[b]) new_w[8*b +: 8] = s_din[8*b +: 8];
        acc = s_en && !m_busy;
        e_valid[0] = acc;
        e_valid[1] = acc;
        if (acc) begin
            e_dout[0] = old_w;
            e_dout[1] = s_we ? new_w : old_w;
        end
        e_valid[2] = p_valid;
        if (p_valid) e_dout[2] = p_data;
        p_valid = acc;
        if (acc) p_data = old_w;
        if (m_busy) begin
            m_mem[m_ptr] = 16'h0;
            if (m_ptr == 2'd3) m_busy = 1'b0;
            m_ptr = m_ptr + 2'd1;
        end else begin
            if (acc && s_we) m_mem[s_addr] = new_w;
            if (s_clr) begin
                m_busy = 1'b1;
                m_ptr  = 2'd0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk1({tag, " busy0"},  if0.busy,       m_busy);
        chk1({tag, " busy1"},  if1.busy,       m_busy);
        chk1({tag, " busy2"},  if2.busy,       m_busy);
        chk1({tag, " valid0"}, if0.dout_valid, e_valid[0]);
        chk1({tag, " valid1"}, if1.dout_valid, e_valid[1]);
        chk1({tag, " valid2"}, if2.dout_valid, e_valid[2]);
        chk({tag, " dout0"},   if0.dout,       e_dout[0]);
        chk({tag, " dout1"},   if1.dout,       e_dout[1]);
        chk({tag, " dout2"},   if2.dout,       e_dout[2]);
    endtask

    task automatic step(input string tag, input bit en, input bit we, input logic [1:0] be,
                        input logic [1:0] addr, input logic [15:0] din, input bit clr);
        drive(en, we, be, addr, din, clr);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 2'd0, 16'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        cnt = 0;
        repeat (4) begin
            if (if0.busy) cnt++;
            step("init_clear", 1'b0, 1'b0, 2'b00, 2'd0, 16'h0, 1'b0);
        end
        chk("init_busy_cycles", 16'(cnt), 16'd4);
        chk1("init_ready", if0.busy, 1'b0);

        for (int a = 0; a < 4; a++) begin
            step("init_read", 1'b1, 1'b0, 2'b00, 2'(a), 16'h0, 1'b0);
            chk("init_read_zero", if0.dout, 16'h0000);
            chk1("init_read_valid", if0.dout_valid, 1'b1);
        end

        step("be_w1", 1'b1, 1'b1, 2'b11, 2'b10, 16'h1234, 1'b0);
        step("be_w2", 1'b1, 1'b1, 2'b10, 2'b10, 16'hABCD, 1'b0);
        step("be_rd", 1'b1, 1'b0, 2'b00, 2'b10, 16'h0, 1'b0);
        chk("be_merge", if0.dout, 16'hAB34);

        step("rdw_w1", 1'b1, 1'b1, 2'b11, 2'd3, 16'h1101, 1'b0);
        step("rdw_w2", 1'b1, 1'b1, 2'b11, 2'd3, 16'h00FF, 1'b0);
        chk("rdw_read_first", if0.dout, 16'h1101);
        chk("rdw_write_first", if1.dout, 16'h00FF);

        step("be0_w", 1'b1, 1'b1, 2'b00, 2'd3, 16'hDEAD, 1'b0);
        step("be0_rd", 1'b1, 1'b0, 2'b00, 2'd3, 16'h0, 1'b0);
        chk("be_zero_nochange", if0.dout, 16'h00FF);

        step("oreg_w", 1'b1, 1'b1, 2'b11, 2'b01, 16'h0009, 1'b0);
        step("oreg_idle", 1'b0, 1'b0, 2'b00, 2'd0, 16'h0, 1'b0);
        step("oreg_rd", 1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 1'b0);
        chk1("oreg_not_yet", if2.dout_valid, 1'b0);
        step("oreg_lat", 1'b0, 1'b0, 2'b00, 2'd0, 16'h0, 1'b0);
        chk1("oreg_valid", if2.dout_valid, 1'b1);
        chk("oreg_data", if2.dout, 16'h0009);

        for (int a = 0; a < 4; a++)
            step("fill", 1'b1, 1'b1, 2'b11, 2'(a), 16'(16'h1111 * (a + 1)), 1'b0);
        step("clr_with_wr", 1'b1, 1'b1, 2'b11, 2'd0, 16'h5A5A, 1'b1);
        cnt = 0;
        for (int a = 0; a < 4; a++) begin
            if (if0.busy) cnt++;
            step("busy_wr", 1'b1, 1'b1, 2'b11, 2'(a), 16'hFFFF, 1'b0);
        end
        chk("clr_busy_cycles", 16'(cnt), 16'd4);
        for (int a = 0; a < 4; a++) begin
            step("post_clr_rd", 1'b1, 1'b0, 2'b00, 2'(a), 16'h0, 1'b0);
            chk("post_clr_zero", if0.dout, 16'h0000);
        end

        step("pipe_w", 1'b1, 1'b1, 2'b11, 2'd2, 16'h7777, 1'b0);
        step("pipe_rd_clr", 1'b1, 1'b0, 2'b00, 2'd2, 16'h0, 1'b1);
        step("pipe_drain", 1'b0, 1'b0, 2'b00, 2'd0, 16'h0, 1'b0);
        chk1("pipe_valid_in_clear", if2.dout_valid, 1'b1);
        chk("pipe_data_in_clear", if2.dout, 16'h7777);

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("held_reset");
        rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            if (if0.busy) cnt++;
            step("reclear", 1'b1, 1'b1, 2'b11, 2'd1, 16'hBEEF, 1'b0);
        end
        chk("reclear_busy_cycles", 16'(cnt), 16'd4);

        repeat (300) begin
            step("rand", 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 16'($urandom), ($urandom_range(15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
